// File: rtl/pipe_pkg.sv
// Shared types for the F/D/X/W pipeline control block: FSM and cycle-kind
// enums, forward-select codes, per-stage bookkeeping and RAW-match helpers.
package pipe_pkg;

  // A stage record can hold register indices up to this width.
  // REG_W must not exceed it.
  localparam int MAX_REG_W = 5;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CYC_IDLE,
    CYC_FREEZE,
    CYC_FLUSH,
    CYC_STALL,
    CYC_ADVANCE
  } cycle_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_LAST = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dst;
    logic                 wr;
    logic                 load;
    logic                 halt;
  } stage_t;

  function automatic logic raw_hit(input logic rd, input logic [MAX_REG_W-1:0] src,
                                   input logic valid, input logic wr,
                                   input logic [MAX_REG_W-1:0] dst);
    return rd && valid && wr && (dst == src);
  endfunction

  // The X producer is younger than the W producer, so it wins the forward.
  function automatic logic [1:0] fwd_pick(input logic rd, input logic [MAX_REG_W-1:0] src,
                                          input logic x_valid, input logic x_wr,
                                          input logic [MAX_REG_W-1:0] x_dst,
                                          input logic w_valid, input logic w_wr,
                                          input logic [MAX_REG_W-1:0] w_dst);
    if (raw_hit(rd, src, x_valid, x_wr, x_dst)) return FWD_WB;
    if (raw_hit(rd, src, w_valid, w_wr, w_dst)) return FWD_LAST;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Clear beats everything; freeze blocks increments.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !i_freeze && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central control for the 4-stage F/D/X/W pipeline.
// It generates stage enables, bubbles, flushes, forward selects, halt and performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W          = 2,
  parameter int CNT_W          = 16,
  parameter bit FWD_EN         = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_src1_rd,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src2_rd,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             id_halt,
  input  logic             ex_branch_taken,
  input  logic             ext_stall,
  input  logic             cnt_clear,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_wb_en,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic             rf_we,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e               r_state;
  logic                 r_v_d;
  logic                 r_halted;
  stage_t               r_x;
  stage_t               r_w;
  logic [1:0]           r_fwd1;
  logic [1:0]           r_fwd2;

  cycle_e               w_cycle;
  stage_t               w_x_next;
  logic [MAX_REG_W-1:0] w_src1;
  logic [MAX_REG_W-1:0] w_src2;
  logic                 w_run;
  logic                 w_hit_x;
  logic                 w_hit_w;
  logic                 w_hazard;
  logic                 w_flush;
  logic                 w_moving;
  logic                 w_retire;
  logic                 w_unused;

  assign w_run  = (r_state == ST_RUN);
  assign w_src1 = MAX_REG_W'(id_src1);
  assign w_src2 = MAX_REG_W'(id_src2);

  assign w_hit_x = raw_hit(id_src1_rd, w_src1, r_x.valid, r_x.wr, r_x.dst) ||
                   raw_hit(id_src2_rd, w_src2, r_x.valid, r_x.wr, r_x.dst);
  assign w_hit_w = raw_hit(id_src1_rd, w_src1, r_w.valid, r_w.wr, r_w.dst) ||
                   raw_hit(id_src2_rd, w_src2, r_w.valid, r_w.wr, r_w.dst);

  assign w_hazard = r_v_d && ((LOAD_USE_STALL && r_x.load && w_hit_x) ||
                              (!FWD_EN && (w_hit_x || w_hit_w)));
  assign w_flush  = r_x.valid && ex_branch_taken;

  // Freeze beats flush, and flush beats the stall.
  // A stall against a wrong-path instruction is therefore discarded.
  always_comb begin
    // NOTE: default first so every path assigns w_cycle and no latch is inferred.
    w_cycle = CYC_ADVANCE;
    if (!w_run)         w_cycle = CYC_IDLE;
    else if (ext_stall) w_cycle = CYC_FREEZE;
    else if (w_flush)   w_cycle = CYC_FLUSH;
    else if (w_hazard)  w_cycle = CYC_STALL;
  end

  assign w_moving = (w_cycle == CYC_ADVANCE) || (w_cycle == CYC_FLUSH) ||
                    (w_cycle == CYC_STALL);

  assign w_x_next = '{valid: r_v_d && (w_cycle == CYC_ADVANCE),
                      dst:   MAX_REG_W'(id_dst),
                      wr:    id_wr,
                      load:  id_load,
                      halt:  id_halt};

  assign pc_en        = (w_cycle == CYC_ADVANCE) || (w_cycle == CYC_FLUSH);
  assign if_id_en     = pc_en;
  assign id_ex_en     = w_moving;
  assign ex_wb_en     = w_moving;
  assign id_ex_bubble = (w_cycle == CYC_STALL);
  assign w_retire     = w_run && r_w.valid && !ext_stall;
  assign rf_we        = w_retire && r_w.wr;
  assign fwd1_sel     = r_fwd1;
  assign fwd2_sel     = r_fwd2;
  assign halted       = r_halted;
  assign w_unused     = r_w.load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_v_d    <= 1'b0;
      r_halted <= 1'b0;
      r_x      <= '0;
      r_w      <= '0;
      r_fwd1   <= FWD_RF;
      r_fwd2   <= FWD_RF;
    end else begin
      // NOTE: non-blocking so r_w takes the pre-edge r_x, not the value just loaded.
      if (w_moving) begin
        r_v_d  <= (w_cycle != CYC_FLUSH);
        r_x    <= w_x_next;
        r_w    <= r_x;
        r_fwd1 <= (FWD_EN && w_x_next.valid)
                  ? fwd_pick(id_src1_rd, w_src1, r_x.valid, r_x.wr, r_x.dst,
                             r_w.valid, r_w.wr, r_w.dst)
                  : FWD_RF;
        r_fwd2 <= (FWD_EN && w_x_next.valid)
                  ? fwd_pick(id_src2_rd, w_src2, r_x.valid, r_x.wr, r_x.dst,
                             r_w.valid, r_w.wr, r_w.dst)
                  : FWD_RF;
      end
      if (w_retire && r_w.halt) begin
        r_state  <= ST_HALTED;
        r_halted <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clock(clock), .reset(reset), .i_inc(w_run), .i_clr(cnt_clear),
    .i_freeze(!w_run), .o_count(cycle_cnt));

  sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clock(clock), .reset(reset), .i_inc(w_retire), .i_clr(cnt_clear),
    .i_freeze(!w_run), .o_count(retired_cnt));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset(reset),
    .i_inc((w_cycle == CYC_FREEZE) || (w_cycle == CYC_STALL)), .i_clr(cnt_clear),
    .i_freeze(!w_run), .o_count(stall_cnt));

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock(clock), .reset(reset), .i_inc(w_cycle == CYC_FLUSH), .i_clr(cnt_clear),
    .i_freeze(!w_run), .o_count(flush_cnt));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// dut_a uses the defaults; dut_b has no load-use stall and 4-bit counters. Both share the same inputs.
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] id_src1, id_src2, id_dst;
  logic       id_src1_rd, id_src2_rd, id_wr, id_load, id_halt;
  logic       ex_branch_taken, ext_stall, cnt_clear;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_wb_en, a_bubble, a_rf_we, a_halted;
  logic [1:0]  a_fwd1, a_fwd2;
  logic [15:0] a_cycle, a_retired, a_stall, a_flush;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_wb_en, b_bubble, b_rf_we, b_halted;
  logic [1:0]  b_fwd1, b_fwd2;
  logic [3:0]  b_cycle, b_retired, b_stall, b_flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl dut_a (
    .clock(clock), .reset(reset),
    .id_src1(id_src1), .id_src1_rd(id_src1_rd), .id_src2(id_src2), .id_src2_rd(id_src2_rd),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall), .cnt_clear(cnt_clear),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en), .ex_wb_en(a_ex_wb_en),
    .id_ex_bubble(a_bubble), .fwd1_sel(a_fwd1), .fwd2_sel(a_fwd2), .rf_we(a_rf_we),
    .halted(a_halted), .cycle_cnt(a_cycle), .retired_cnt(a_retired),
    .stall_cnt(a_stall), .flush_cnt(a_flush));

  pipe_hazard_ctrl #(.CNT_W(4), .LOAD_USE_STALL(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .id_src1(id_src1), .id_src1_rd(id_src1_rd), .id_src2(id_src2), .id_src2_rd(id_src2_rd),
    .id_dst(id_dst), .id_wr(id_wr), .id_load(id_load), .id_halt(id_halt),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall), .cnt_clear(cnt_clear),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en), .ex_wb_en(b_ex_wb_en),
    .id_ex_bubble(b_bubble), .fwd1_sel(b_fwd1), .fwd2_sel(b_fwd2), .rf_we(b_rf_we),
    .halted(b_halted), .cycle_cnt(b_cycle), .retired_cnt(b_retired),
    .stall_cnt(b_stall), .flush_cnt(b_flush));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the D-stage instruction: src1, rd1, src2, rd2, dst, wr, load, halt.
  task automatic dr(input logic [1:0] s1, input logic r1, input logic [1:0] s2, input logic r2,
                    input logic [1:0] d, input logic w, input logic ld, input logic h);
    id_src1 = s1; id_src1_rd = r1; id_src2 = s2; id_src2_rd = r2;
    id_dst = d; id_wr = w; id_load = ld; id_halt = h;
  endtask

  // Leaves the bench in cycle c0 (v_d still 0), 3 time units after an edge.
  task automatic do_reset();
    reset = 1'b1; ext_stall = 1'b0; ex_branch_taken = 1'b0; cnt_clear = 1'b0;
    dr(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #3 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ext_stall = 1'b0; ex_branch_taken = 1'b0; cnt_clear = 1'b0;
    dr(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_halted", 32'(a_halted), 0);
    check("rst_cycle", 32'(a_cycle), 0);
    check("rst_fwd", 32'({a_fwd1, a_fwd2}), 0);
    check("rst_rf_we", 32'(a_rf_we), 0);
    check("rst_bubble", 32'(a_bubble), 0);

    // ALU RAW: add r1 ; sub r1 ; third r1 ; nop ; late r1
    do_reset(); tick();
    dr(2, 1, 3, 1, 1, 1, 0, 0); tick();
    dr(1, 1, 3, 1, 2, 1, 0, 0); #1;
    check("raw_no_stall_pc", 32'(a_pc_en), 1);
    check("raw_no_bubble", 32'(a_bubble), 0);
    tick();
    check("raw_fwd1_x", 32'(a_fwd1), 1);
    check("raw_fwd2_none", 32'(a_fwd2), 0);
    check("raw_add_rf_we", 32'(a_rf_we), 1);
    dr(1, 1, 0, 0, 3, 1, 0, 0); tick();
    check("raw_fwd1_w", 32'(a_fwd1), 2);
    dr(0, 0, 0, 0, 0, 0, 0, 0); tick();
    dr(1, 1, 0, 0, 0, 0, 0, 0); tick();
    check("raw_fwd1_late", 32'(a_fwd1), 0);
    check("raw_retired", 32'(a_retired), 3);
    check("raw_stall_cnt", 32'(a_stall), 0);

    // Load-use: load r2 ; add reads r2 as src1 (src2=r2 but not read)
    do_reset(); tick();
    dr(0, 0, 0, 0, 2, 1, 1, 0); tick();
    dr(2, 1, 2, 0, 3, 1, 0, 0); #1;
    check("lu_pc_en", 32'(a_pc_en), 0);
    check("lu_if_id_en", 32'(a_if_id_en), 0);
    check("lu_id_ex_en", 32'(a_id_ex_en), 1);
    check("lu_bubble", 32'(a_bubble), 1);
    check("lu_ex_wb_en", 32'(a_ex_wb_en), 1);
    check("lu_nostall_b_pc_en", 32'(b_pc_en), 1);
    check("lu_nostall_b_bubble", 32'(b_bubble), 0);
    tick();
    check("lu_stall_cnt", 32'(a_stall), 1);
    check("lu_bubble_fwd1", 32'(a_fwd1), 0);
    check("lu_b_fwd1", 32'(b_fwd1), 1);
    check("lu_b_stall_cnt", 32'(b_stall), 0);
    check("lu_resume_pc_en", 32'(a_pc_en), 1);
    tick();
    check("lu_fwd1_last", 32'(a_fwd1), 2);
    check("lu_fwd2_unread", 32'(a_fwd2), 0);
    check("lu_single_stall", 32'(a_stall), 1);

    // Taken branch in X (load-flagged, so a load-use match coincides)
    do_reset(); tick();
    dr(0, 0, 0, 0, 2, 1, 1, 0); tick();
    dr(2, 1, 0, 0, 1, 1, 0, 0); ex_branch_taken = 1'b1; #1;
    check("fl_pc_en", 32'(a_pc_en), 1);
    check("fl_id_ex_en", 32'(a_id_ex_en), 1);
    check("fl_no_bubble", 32'(a_bubble), 0);
    check("fl_ex_wb_en", 32'(a_ex_wb_en), 1);
    tick();
    check("fl_flush_cnt", 32'(a_flush), 1);
    check("fl_no_stall_cnt", 32'(a_stall), 0);
    check("fl_branch_rf_we", 32'(a_rf_we), 1);
    dr(0, 0, 0, 0, 0, 0, 0, 0); tick();
    check("fl_needs_v_x", 32'(a_flush), 1);
    check("fl_bubble1_rf_we", 32'(a_rf_we), 0);
    ex_branch_taken = 1'b0; tick();
    check("fl_bubble2_rf_we", 32'(a_rf_we), 0);
    tick();
    check("fl_retired", 32'(a_retired), 1);

    // ext_stall for 3 cycles with a taken branch in X and a writer in W
    do_reset(); tick();
    dr(0, 0, 0, 0, 1, 1, 0, 0); tick();
    dr(0, 0, 0, 0, 0, 0, 0, 0); tick();
    ext_stall = 1'b1; ex_branch_taken = 1'b1; #1;
    check("es_enables", 32'({a_pc_en, a_if_id_en, a_id_ex_en, a_ex_wb_en}), 0);
    check("es_rf_we", 32'(a_rf_we), 0);
    tick(); tick(); tick();
    check("es_stall_cnt", 32'(a_stall), 3);
    check("es_no_flush_yet", 32'(a_flush), 0);
    ext_stall = 1'b0; #1;
    check("es_flush_pc_en", 32'(a_pc_en), 1);
    check("es_release_rf_we", 32'(a_rf_we), 1);
    tick();
    ex_branch_taken = 1'b0;
    check("es_flush_cnt", 32'(a_flush), 1);
    check("es_retired", 32'(a_retired), 1);
    check("es_cycle_cnt", 32'(a_cycle), 7);
    check("es_stall_final", 32'(a_stall), 3);

    // Asynchronous reset while v_x=1 and ext_stall=1
    do_reset(); tick();
    dr(0, 0, 0, 0, 1, 1, 0, 0); tick();
    ext_stall = 1'b1; tick();
    check("ar_pre_stall", 32'(a_stall), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_outs_zero", 32'({a_pc_en, a_if_id_en, a_id_ex_en, a_ex_wb_en, a_bubble,
                              a_fwd1, a_fwd2, a_rf_we, a_halted}), 0);
    check("ar_counters_zero", 32'({a_stall, a_cycle}), 0);
    #2 reset = 1'b0; ext_stall = 1'b0;
    tick(); tick();
    check("ar_no_residual_rf_we", 32'(a_rf_we), 0);
    tick();
    check("ar_first_write", 32'(a_rf_we), 1);

    // Halt: halt ; add r1 ; add r2
    do_reset(); tick();
    dr(0, 0, 0, 0, 0, 0, 0, 1); tick();
    dr(0, 0, 0, 0, 1, 1, 0, 0); tick();
    dr(0, 0, 0, 0, 2, 1, 0, 0); #1;
    check("ht_not_yet", 32'(a_halted), 0);
    tick();
    check("ht_halted", 32'(a_halted), 1);
    check("ht_enables", 32'({a_pc_en, a_if_id_en, a_id_ex_en, a_ex_wb_en, a_bubble}), 0);
    check("ht_younger_rf_we", 32'(a_rf_we), 0);
    check("ht_cycle", 32'(a_cycle), 4);
    check("ht_retired", 32'(a_retired), 1);
    tick(); tick(); tick();
    check("ht_cycle_frozen", 32'(a_cycle), 4);
    check("ht_retired_frozen", 32'(a_retired), 1);
    check("ht_still_halted", 32'(a_halted), 1);
    check("ht_rf_we_frozen", 32'(a_rf_we), 0);

    // Saturation (dut_b has 4-bit counters) and synchronous clear
    do_reset();
    check("sat_unhalted", 32'(a_halted), 0);
    repeat (20) tick();
    check("sat_b_cycle", 32'(b_cycle), 15);
    check("sat_a_cycle", 32'(a_cycle), 20);
    cnt_clear = 1'b1; tick();
    check("clr_a_cycle", 32'(a_cycle), 0);
    check("clr_b_cycle", 32'(b_cycle), 0);
    check("clr_b_retired", 32'(b_retired), 0);
    cnt_clear = 1'b0; tick();
    check("clr_restart", 32'(a_cycle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline control for the 4-stage F/D/X/W processor: F = fetch into IR_1, D = RF read, X = ALU/memory/branch, W = RF write-back from WBin.
- Replaces the per-stage free-running load enables. Tracks per-stage valid bits and destination info, and generates stage enables, bubbles, flushes and operand-forward selects.
- Supports halt.
- Hosts parametrised saturating performance counters: cycles, retired, stalls, flushes.

Parameters:
- REG_W, 2, register-index width (2^REG_W architectural registers).
- CNT_W, 16, performance counter width.
- FWD_EN, 1, 1 = generate forward selects; 0 = force fwd*_sel = 00 and stall on any RAW hazard against X or W.
- LOAD_USE_STALL, 1, 1 = load result not forwardable from X, so insert 1-cycle stall on load-use.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- id_src1  in  REG_W  D-stage source-1 index
- id_src1_rd  in  1  D instruction reads src1
- id_src2  in  REG_W  D-stage source-2 index
- id_src2_rd  in  1  D instruction reads src2
- id_dst  in  REG_W  D-stage destination index
- id_wr  in  1  D instruction writes RF
- id_load  in  1  D instruction is a load
- id_halt  in  1  D instruction is halt
- ex_branch_taken  in  1  X-stage branch resolved taken (PC mux already on target)
- ext_stall  in  1  external freeze request
- cnt_clear  in  1  synchronous counter clear
- pc_en  out  1  PC write enable
- if_id_en  out  1  IR_1→IR_2 / PC pipe advance
- id_ex_en  out  1  IR_2→IR_3, R1/R2, extension regs advance
- ex_wb_en  out  1  IR_3→IR_4, WBin advance
- id_ex_bubble  out  1  load NOP into X
- fwd1_sel  out  2  X operand-1 source: 00 R1, 01 WBin, 10 last-written RF data
- fwd2_sel  out  2  same for operand 2
- rf_we  out  1  gated RF write enable
- halted  out  1  processor halted
- cycle_cnt  out  CNT_W  cycle counter
- retired_cnt  out  CNT_W  retired-instruction counter
- stall_cnt  out  CNT_W  stall counter
- flush_cnt  out  CNT_W  flush counter

Behaviour:
- Reset (async): FSM=RUN; v_d=v_x=v_w=0; stored x/w fields=0; fwd sels=00; counters=0; halted=0. The fetch slot is always valid while RUN.
- Per-stage stored fields, captured when an instruction advances: dst, wr, load, halt (D→X on id_ex_en & ~bubble; X→W on ex_wb_en).
- FSM states:
  - RUN → HALTED when v_w & w_halt & ~ext_stall.
  - HALTED exits only by reset.
- In HALTED: all enables, rf_we and the bubble flag are 0; counters frozen; halted=1. Instructions younger than the halt are discarded.
- Per-cycle priority in RUN: ext_stall > branch flush > hazard stall > advance.
  - ext_stall: all enables 0, valids and fields hold, rf_we=0, stall_cnt+1.
  - flush (v_x & ex_branch_taken): all enables 1; v_d'=0; v_x'=0; flush_cnt+1. A hazard stall in the same cycle is discarded (wrong path).
  - hazard stall:
    - Condition: v_d & v_x & x_wr & x_load & LOAD_USE_STALL, and a read source equals x_dst.
    - Also when FWD_EN=0: any read source matches a valid writing X or W dst.
    - Response: pc_en=if_id_en=0; id_ex_en=1 with id_ex_bubble=1 (v_x'=0); ex_wb_en=1; stall_cnt+1.
  - advance: all enables 1; v_d'=1, v_x'=v_d, v_w'=v_x.
- Forward selects are registered with D→X, so they are valid while the consumer is in X:
  - 01 if the source matches a valid writing X producer.
  - Else 10 if it matches a valid writing W producer.
  - Else 00.
  - Sources not read get 00.
- The block holds no data register itself; the "last-written RF data" register is a WB-datapath item.
- Register index 0 gets no special treatment.
- rf_we = v_w & w_wr & ~ext_stall & RUN.
- Retire: v_w & ~ext_stall & RUN → retired_cnt+1 (bubbles and flushed slots never count).
- cycle_cnt +1 every RUN cycle.
- Counters saturate at all-ones. cnt_clear zeroes all four and has priority over the increment in the same cycle.
- Reset mid-stall or mid-flush: everything returns to reset values immediately; no residual bubble.

Decomposition:
- Package pipe_pkg holds:
  - FSM state enum (RUN, HALTED).
  - Forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_LAST=2'b10.
  - Stage-info struct {valid, dst, wr, load, halt}.
- Sub-module sat_counter (CNT_W, inc, clr, freeze), instantiated 4×.

Test Plan:
- Reset mid-operation: assert reset while v_x=1 and ext_stall=1 → all outputs 0 asynchronously, FSM=RUN; after release, v_d rises on the first clock.
- ALU RAW: add r1 then sub using r1 as src1, FWD_EN=1 → consumer in X has fwd1_sel=01, no stall. A third instruction reading r1 gets 10 if issued next, 00 otherwise.
- Load-use: load r2 then add reading r2 → exactly 1 bubble; stall_cnt=1; the add reaches X with fwd sel=10. With LOAD_USE_STALL=0 → no stall, fwd sel=01.
- Branch taken in X → v_d, v_x cleared, 2 bubbles reach W with rf_we=0; flush_cnt=1. A coincident load-use stall produces no extra stall_cnt.
- ext_stall held 3 cycles while a taken branch is in X → enables 0, stall_cnt+3, rf_we=0; the flush occurs on the first unstalled cycle.
- Halt: halt retires → halted=1 next cycle, counters frozen, the younger add never writes. With CNT_W=4, run 20 cycles → cycle_cnt=15; then cnt_clear → 0.
